// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM encoding, default sizing and bus mode constants.
package spi_slave_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Mode 0; the same constants parameterize the spi0 master.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

  // Bit counter must hold DATA_WIDTH itself, so one bit beyond clog2.
  function automatic int unsigned bitcnt_width(input int unsigned w);
    return unsigned'($clog2(w)) + 1;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes sclk/ss/mosi into the io_clock domain and decodes edges.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_level,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev;
  logic                   ss_prev;
  logic                   sclk_s;
  logic                   ss_s;

  // Synchronizer chains; ss resets deasserted so reset never fakes a select edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk ^ SPI_CPOL};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];

  // Previous synchronized level, the reference for edge decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign ss_level  = ss_s;
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with one-entry RX/TX byte streams toward the SoC fabric.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  io_clock,
  input  logic                  io_reset,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_ss,
  input  logic                  io_spi_mosi,
  output logic                  io_spi_miso_write,
  output logic                  io_spi_miso_writeEnable,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_overrun,
  output logic                  io_underrun
);

  localparam int unsigned    CNT_W    = bitcnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  ss_fall;
  logic                  ss_rise;
  logic                  ss_level;
  logic                  mosi_sync;
  logic                  sample_edge;
  logic                  shift_edge;

  spi_state_t            state;
  logic [CNT_W-1:0]      bitcnt;
  logic [CNT_W-1:0]      bitcnt_inc;
  logic                  reload_armed;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_hold;
  logic [DATA_WIDTH-1:0] tx_load;

  spi_slave_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (io_clock),
    .rst       (io_reset),
    .sclk      (io_spi_sclk),
    .ss        (io_spi_ss),
    .mosi      (io_spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .ss_level  (ss_level),
    .mosi_sync (mosi_sync)
  );

  // Mode 0 samples on the leading edge and shifts on the trailing edge.
  assign sample_edge = (SPI_CPHA == 1'b0) ? sclk_rise : sclk_fall;
  assign shift_edge  = (SPI_CPHA == 1'b0) ? sclk_fall : sclk_rise;

  assign bitcnt_inc = bitcnt + CNT_W'(1);
  assign rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_sync};

  // Word fed to the shifter on a load: the hold if full, otherwise zero.
  assign tx_load = io_tx_ready ? '0 : tx_hold;

  // Transfer FSM, TX hold register and MISO pad drive.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      state                   <= ST_IDLE;
      bitcnt                  <= '0;
      reload_armed            <= 1'b0;
      word_done               <= 1'b0;
      rx_shift                <= '0;
      rx_word                 <= '0;
      tx_shift                <= '0;
      tx_hold                 <= '0;
      io_tx_ready             <= 1'b1;
      io_spi_miso_write       <= 1'b0;
      io_spi_miso_writeEnable <= 1'b0;
      io_underrun             <= 1'b0;
    end else begin
      io_underrun <= 1'b0;
      word_done   <= 1'b0;

      // Producer handshake; a load in this cycle still sees the old (empty) hold.
      if (io_tx_valid && io_tx_ready) begin
        tx_hold     <= io_tx_payload;
        io_tx_ready <= 1'b0;
      end

      if (ss_rise) begin
        // Deselect aborts any partial word; the TX hold is left alone.
        state                   <= ST_IDLE;
        io_spi_miso_writeEnable <= 1'b0;
        bitcnt                  <= '0;
        reload_armed            <= 1'b0;
        rx_shift                <= '0;
        tx_shift                <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            io_spi_miso_writeEnable <= 1'b0;
            bitcnt                  <= '0;
            reload_armed            <= 1'b0;
            if (ss_fall && !ss_level) begin
              state <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            tx_shift                <= tx_load;
            io_spi_miso_write       <= tx_load[DATA_WIDTH-1];
            io_spi_miso_writeEnable <= 1'b1;
            if (io_tx_ready) begin
              io_underrun <= 1'b1;
            end else begin
              io_tx_ready <= 1'b1;
            end
            state <= ST_SHIFT;
          end

          ST_SHIFT: begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bitcnt_inc == CNT_FULL) begin
                rx_word      <= rx_next;
                word_done    <= 1'b1;
                bitcnt       <= '0;
                reload_armed <= 1'b1;
              end else begin
                bitcnt <= bitcnt_inc;
              end
            end else if (shift_edge) begin
              if (reload_armed) begin
                // Back-to-back word: reload on the trailing edge of the last bit.
                reload_armed      <= 1'b0;
                tx_shift          <= tx_load;
                io_spi_miso_write <= tx_load[DATA_WIDTH-1];
                if (io_tx_ready) begin
                  io_underrun <= 1'b1;
                end else begin
                  io_tx_ready <= 1'b1;
                end
              end else if (bitcnt != '0 && bitcnt != CNT_FULL) begin
                tx_shift          <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                io_spi_miso_write <= tx_shift[DATA_WIDTH-2];
              end
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // One-entry RX buffer; a completed word is dropped only when the buffer is full and not draining.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      io_rx_valid   <= 1'b0;
      io_rx_payload <= '0;
      io_overrun    <= 1'b0;
    end else begin
      io_overrun <= 1'b0;
      if (word_done) begin
        if (io_rx_valid && !io_rx_ready) begin
          io_overrun <= 1'b1;
        end else begin
          io_rx_payload <= rx_word;
          io_rx_valid   <= 1'b1;
        end
      end else if (io_rx_valid && io_rx_ready) begin
        io_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master model, directed vectors and randomized windows.
module tb_spi_slave;

  localparam int unsigned W    = 8;
  localparam int unsigned HALF = 4;  // sclk half period in io_clock cycles (sclk = io_clock/8)

  logic         io_clock = 1'b0;
  logic         io_reset;
  logic         sclk;
  logic         ss;
  logic         mosi;
  logic         miso_w;
  logic         miso_we;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] rx_payload;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_payload;
  logic         overrun;
  logic         underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Written only by the monitor process.
  int         und_cnt = 0;
  int         ovr_cnt = 0;
  int         rx_wr   = 0;
  logic [7:0] rx_log [0:1023];

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    bit         preload;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs [5];

  spi_slave dut (
    .io_clock                (io_clock),
    .io_reset                (io_reset),
    .io_spi_sclk             (sclk),
    .io_spi_ss               (ss),
    .io_spi_mosi             (mosi),
    .io_spi_miso_write       (miso_w),
    .io_spi_miso_writeEnable (miso_we),
    .io_rx_valid             (rx_valid),
    .io_rx_ready             (rx_ready),
    .io_rx_payload           (rx_payload),
    .io_tx_valid             (tx_valid),
    .io_tx_ready             (tx_ready),
    .io_tx_payload           (tx_payload),
    .io_overrun              (overrun),
    .io_underrun             (underrun)
  );

  always #5 io_clock = ~io_clock;

  // Counts pulses and logs every accepted RX word.
  always @(posedge io_clock) begin
    if (!io_reset) begin
      if (underrun) und_cnt <= und_cnt + 1;
      if (overrun)  ovr_cnt <= ovr_cnt + 1;
      if (rx_valid && rx_ready) begin
        rx_log[rx_wr[9:0]] <= rx_payload;
        rx_wr              <= rx_wr + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge io_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rx(input string name, input int idx, input logic [7:0] exp);
    if (idx < rx_wr) begin
      chk(name, 32'(rx_log[idx[9:0]]), 32'(exp));
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no word logged at index %0d, expected %0h", name, idx, exp);
    end
  endtask

  task automatic tx_offer(input logic [7:0] b);
    chk("tx_ready_before_offer", 32'(tx_ready), 32'd1);
    tx_valid   = 1'b1;
    tx_payload = b;
    tick(1);
    tx_valid   = 1'b0;
    chk("tx_ready_after_offer", 32'(tx_ready), 32'd0);
  endtask

  // Master side of one word. The final word of a select window raises ss together with the
  // trailing sclk edge, so no reload is triggered after it.
  task automatic spi_word(input logic [7:0] mo, input int nbits, input bit last, input bit offer,
                          input logic [7:0] ob, input bit check_lat, output logic [7:0] mi);
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      mosi = mo[3'(7 - b)];
      if (offer && b == 3) begin
        tx_offer(ob);
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      sclk = 1'b1;
      mi   = {mi[6:0], miso_w};
      if (check_lat && b == 7) begin
        tick(3);
        chk("rx_valid_latency_early", 32'(rx_valid), 32'd0);
        tick(1);
        chk("rx_valid_latency_on", 32'(rx_valid), 32'd1);
      end else begin
        tick(HALF);
      end
      sclk = 1'b0;
      if (last && b == nbits - 1) ss = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] m0;
    logic [7:0] m1;
    int         und0;
    int         ovr0;
    int         rx0;
    int         bad;
    logic [7:0] exp_rx [$];
    int         exp_und;

    vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, preload: 1'b1, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_und: 0};
    vecs[1] = '{mosi: 8'h00, tx: 8'hFF, preload: 1'b1, exp_miso: 8'hFF, exp_rx: 8'h00, exp_und: 0};
    vecs[2] = '{mosi: 8'hFF, tx: 8'h00, preload: 1'b1, exp_miso: 8'h00, exp_rx: 8'hFF, exp_und: 0};
    vecs[3] = '{mosi: 8'h81, tx: 8'h7E, preload: 1'b1, exp_miso: 8'h7E, exp_rx: 8'h81, exp_und: 0};
    vecs[4] = '{mosi: 8'h5A, tx: 8'hC3, preload: 1'b0, exp_miso: 8'h00, exp_rx: 8'h5A, exp_und: 1};

    io_reset   = 1'b1;
    sclk       = 1'b0;
    ss         = 1'b1;
    mosi       = 1'b0;
    rx_ready   = 1'b1;
    tx_valid   = 1'b0;
    tx_payload = '0;
    tick(3);
    chk("rst_miso_we", 32'(miso_we), 32'd0);
    chk("rst_miso_w", 32'(miso_w), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_payload", 32'(rx_payload), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    io_reset = 1'b0;

    // Idle with ss high: nothing may move.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (miso_we || rx_valid || underrun || overrun || !tx_ready) bad++;
    end
    chk("idle_quiet_cycles", 32'(bad), 32'd0);

    // Single-word vectors.
    for (int v = 0; v < 5; v++) begin
      und0 = und_cnt;
      rx0  = rx_wr;
      if (vecs[v].preload) tx_offer(vecs[v].tx);
      ss = 1'b0;
      tick(8);
      chk("load_drives_miso", 32'(miso_we), 32'd1);
      chk("tx_ready_after_load", 32'(tx_ready), 32'd1);
      spi_word(vecs[v].mosi, 8, 1'b1, 1'b0, 8'h00, 1'b1, m0);
      tick(8);
      chk("single_miso", 32'(m0), 32'(vecs[v].exp_miso));
      chk_rx("single_rx", rx0, vecs[v].exp_rx);
      chk("single_underrun", 32'(und_cnt - und0), 32'(vecs[v].exp_und));
      chk("single_we_off", 32'(miso_we), 32'd0);
    end

    // Back-to-back words in one select window, second TX word written mid-transfer.
    und0 = und_cnt;
    rx0  = rx_wr;
    tx_offer(8'h11);
    ss = 1'b0;
    tick(8);
    spi_word(8'hF0, 8, 1'b0, 1'b1, 8'h22, 1'b1, m0);
    spi_word(8'h0F, 8, 1'b1, 1'b0, 8'h00, 1'b1, m1);
    tick(8);
    chk("b2b_miso0", 32'(m0), 32'h11);
    chk("b2b_miso1", 32'(m1), 32'h22);
    chk_rx("b2b_rx0", rx0, 8'hF0);
    chk_rx("b2b_rx1", rx0 + 1, 8'h0F);
    chk("b2b_underrun", 32'(und_cnt - und0), 32'd0);

    // Underrun and overrun: empty hold, consumer stalled.
    rx_ready = 1'b0;
    und0 = und_cnt;
    ovr0 = ovr_cnt;
    rx0  = rx_wr;
    ss = 1'b0;
    tick(8);
    spi_word(8'hC3, 8, 1'b0, 1'b0, 8'h00, 1'b0, m0);
    spi_word(8'h3C, 8, 1'b1, 1'b0, 8'h00, 1'b0, m1);
    tick(8);
    chk("uo_miso0", 32'(m0), 32'h00);
    chk("uo_miso1", 32'(m1), 32'h00);
    chk("uo_underrun", 32'(und_cnt - und0), 32'd2);
    chk("uo_overrun", 32'(ovr_cnt - ovr0), 32'd1);
    chk("uo_rx_valid", 32'(rx_valid), 32'd1);
    chk("uo_rx_payload_kept", 32'(rx_payload), 32'hC3);
    rx_ready = 1'b1;
    tick(2);
    chk("uo_rx_drained", 32'(rx_valid), 32'd0);
    chk_rx("uo_rx_first", rx0, 8'hC3);
    chk("uo_rx_count", 32'(rx_wr - rx0), 32'd1);

    // Abort after 5 bits, then a clean word.
    und0 = und_cnt;
    rx0  = rx_wr;
    ss = 1'b0;
    tick(8);
    spi_word(8'hFF, 5, 1'b1, 1'b0, 8'h00, 1'b0, m0);
    tick(8);
    chk("abort_we_off", 32'(miso_we), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_no_rx", 32'(rx_wr - rx0), 32'd0);
    ss = 1'b0;
    tick(8);
    spi_word(8'h96, 8, 1'b1, 1'b0, 8'h00, 1'b1, m0);
    tick(8);
    chk_rx("abort_next_rx", rx0, 8'h96);
    chk("abort_underrun", 32'(und_cnt - und0), 32'd2);

    // Randomized select windows against a word-level model.
    und0 = und_cnt;
    ovr0 = ovr_cnt;
    rx0  = rx_wr;
    exp_und = 0;
    exp_rx.delete();
    for (int w = 0; w < 12; w++) begin
      int         nw;
      bit         abort;
      logic [7:0] wmo [3];
      logic [7:0] wtx [3];
      bit         has [3];
      nw    = int'($urandom_range(1, 3));
      abort = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 3; k++) begin
        wmo[k] = 8'($urandom);
        wtx[k] = 8'($urandom);
        has[k] = 1'($urandom);
      end
      if (has[0]) tx_offer(wtx[0]);
      ss = 1'b0;
      tick(8);
      for (int k = 0; k < nw; k++) begin
        int nb;
        bit off;
        nb  = (abort && k == nw - 1) ? int'($urandom_range(1, 7)) : 8;
        off = (k + 1 < nw) && has[k + 1];
        if (!has[k]) exp_und++;
        spi_word(wmo[k], nb, k == nw - 1, off, off ? wtx[k + 1] : 8'h00, 1'b0, m0);
        if (nb == 8) begin
          chk("rand_miso", 32'(m0), has[k] ? 32'(wtx[k]) : 32'd0);
          exp_rx.push_back(wmo[k]);
        end
      end
      tick(8);
      chk("rand_we_off", 32'(miso_we), 32'd0);
    end
    chk("rand_rx_count", 32'(rx_wr - rx0), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size(); i++) chk_rx("rand_rx", rx0 + i, exp_rx[i]);
    chk("rand_underrun", 32'(und_cnt - und0), 32'(exp_und));
    chk("rand_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // Reset in the middle of a word, with RX full and the TX hold occupied.
    rx_ready = 1'b0;
    ss = 1'b0;
    tick(8);
    spi_word(8'h5A, 8, 1'b0, 1'b0, 8'h00, 1'b0, m0);
    spi_word(8'hFF, 3, 1'b0, 1'b0, 8'h00, 1'b0, m0);
    tx_offer(8'hE7);
    chk("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
    chk("pre_rst_rx_payload", 32'(rx_payload), 32'h5A);
    chk("pre_rst_we", 32'(miso_we), 32'd1);
    io_reset = 1'b1;
    #1;
    chk("midrst_miso_we", 32'(miso_we), 32'd0);
    chk("midrst_miso_w", 32'(miso_w), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_rx_payload", 32'(rx_payload), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_underrun", 32'(underrun), 32'd0);
    tick(3);
    sclk     = 1'b0;
    ss       = 1'b1;
    rx_ready = 1'b1;
    io_reset = 1'b0;
    tick(5);
    und0 = und_cnt;
    rx0  = rx_wr;
    tx_offer(8'h69);
    ss = 1'b0;
    tick(8);
    spi_word(8'hB4, 8, 1'b1, 1'b0, 8'h00, 1'b1, m0);
    tick(8);
    chk("post_rst_miso", 32'(m0), 32'h69);
    chk_rx("post_rst_rx", rx0, 8'hB4);
    chk("post_rst_underrun", 32'(und_cnt - und0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
